// File: rtl/multdiv_pkg.sv
// Shared types and constants for the signed 32-bit multiply/divide sequencer.
package multdiv_pkg;
  localparam int DATA_W    = 32;
  localparam int DIV_STEPS = 32;
  localparam int CNT_W     = 8;
  localparam logic [DATA_W-1:0] INT_MIN = 32'h8000_0000;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    MUL  = 3'd1,
    DIV  = 3'd2,
    FIX  = 3'd3,
    DONE = 3'd4
  } state_e;

  // Two's-complement magnitude; INT_MIN wraps to 32'h8000_0000, which is exact unsigned.
  function automatic logic [DATA_W-1:0] abs32(input logic [DATA_W-1:0] v);
    abs32 = v[DATA_W-1] ? (~v + 32'd1) : v;
  endfunction
endpackage

// File: rtl/multdiv_controller_div_step.sv
// One combinational restoring-division iteration on unsigned magnitudes.
module div_step
  import multdiv_pkg::*;
(
  input  logic [DATA_W:0]   rem_in,
  input  logic [DATA_W-1:0] q_in,
  input  logic [DATA_W-1:0] divisor,
  output logic [DATA_W:0]   rem_out,
  output logic [DATA_W-1:0] q_out
);
  logic [DATA_W+1:0] shifted_s;
  logic [DATA_W:0]   trial_s;
  logic              fits_s;

  // Shift in the next dividend bit, subtract the divisor, restore on borrow.
  always_comb begin
    shifted_s = {rem_in, q_in[DATA_W-1]};
    fits_s    = (shifted_s >= {2'b00, divisor});
    trial_s   = shifted_s[DATA_W:0] - {1'b0, divisor};
    if (fits_s) begin
      rem_out = trial_s;
      q_out   = {q_in[DATA_W-2:0], 1'b1};
    end else begin
      rem_out = shifted_s[DATA_W:0];
      q_out   = {q_in[DATA_W-2:0], 1'b0};
    end
  end
endmodule

// File: rtl/thirty_two_wallace_multipiler.sv
// Combinational signed 32x32 multiplier: low product word plus signed-overflow flag.
module thirty_two_wallace_multipiler (
  input  logic [31:0] multiplicand,
  input  logic [31:0] multiplier,
  output logic [31:0] product,
  output logic        ovf
);
  logic signed [63:0] full_s;

  // Overflow when the upper word is not a sign extension of bit 31.
  always_comb begin
    full_s  = 64'($signed(multiplicand)) * 64'($signed(multiplier));
    product = full_s[31:0];
    ovf     = (full_s[63:32] != {32{full_s[31]}});
  end
endmodule

// File: rtl/multdiv_controller.sv
// Sequencer for signed multiply (registered Wallace capture) and 32-step restoring divide.
module multdiv_controller
  import multdiv_pkg::*;
#(
  parameter int MULT_LAT = 2,
  parameter int RDY_HOLD = 0
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              ctrl_MULT,
  input  logic              ctrl_DIV,
  input  logic [DATA_W-1:0] data_operandA,
  input  logic [DATA_W-1:0] data_operandB,
  output logic [DATA_W-1:0] data_result,
  output logic              data_exception,
  output logic              data_resultRDY,
  output logic              busy
);
  localparam logic [CNT_W-1:0] LAT_C  = CNT_W'(MULT_LAT);
  localparam logic [CNT_W-1:0] LAST_C = CNT_W'(DIV_STEPS - 1);

  state_e            state_r, state_s;
  logic [CNT_W-1:0]  cnt_r, cnt_s;
  logic [DATA_W-1:0] mul_a_r, mul_a_s, mul_b_r, mul_b_s;
  logic [DATA_W-1:0] q_r, q_s, divisor_r, divisor_s;
  logic [DATA_W:0]   rem_r, rem_s;
  logic              sign_r, sign_s, special_r, special_s;
  logic [DATA_W-1:0] result_r, result_s;
  logic              exc_r, exc_s, rdy_r, rdy_s, busy_r, busy_s;
  logic [DATA_W-1:0] product_s, step_q_s;
  logic [DATA_W:0]   step_rem_s;
  logic              ovf_s;

  thirty_two_wallace_multipiler u_mult (
    .multiplicand (mul_a_r),
    .multiplier   (mul_b_r),
    .product      (product_s),
    .ovf          (ovf_s)
  );

  div_step u_step (
    .rem_in  (rem_r),
    .q_in    (q_r),
    .divisor (divisor_r),
    .rem_out (step_rem_s),
    .q_out   (step_q_s)
  );

  // Next-state and next-output logic; a new request always wins and aborts any op in flight.
  always_comb begin
    state_s = state_r;  cnt_s = cnt_r;  mul_a_s = mul_a_r;  mul_b_s = mul_b_r;
    q_s = q_r;  divisor_s = divisor_r;  rem_s = rem_r;  sign_s = sign_r;
    special_s = special_r;  result_s = result_r;  exc_s = exc_r;
    rdy_s = rdy_r;  busy_s = busy_r;
    if (ctrl_MULT || ctrl_DIV) begin
      rdy_s  = 1'b0;
      busy_s = 1'b1;
      if (ctrl_MULT) begin
        state_s = MUL;
        cnt_s   = CNT_W'(1);
        mul_a_s = data_operandA;
        mul_b_s = data_operandB;
      end else begin
        state_s   = DIV;
        cnt_s     = '0;
        q_s       = abs32(data_operandA);
        divisor_s = abs32(data_operandB);
        rem_s     = '0;
        sign_s    = data_operandA[DATA_W-1] ^ data_operandB[DATA_W-1];
        special_s = (data_operandA == INT_MIN) && (data_operandB == 32'hFFFF_FFFF);
      end
    end else begin
      case (state_r)
        IDLE: state_s = IDLE;
        MUL: begin
          if (cnt_r == LAT_C) begin
            result_s = product_s;
            exc_s    = ovf_s;
            rdy_s    = 1'b1;
            busy_s   = 1'b0;
            state_s  = DONE;
          end else begin
            cnt_s = cnt_r + CNT_W'(1);
          end
        end
        DIV: begin
          if (divisor_r == '0) begin
            result_s = '0;
            exc_s    = 1'b1;
            rdy_s    = 1'b1;
            busy_s   = 1'b0;
            state_s  = DONE;
          end else begin
            rem_s = step_rem_s;
            q_s   = step_q_s;
            cnt_s = cnt_r + CNT_W'(1);
            if (cnt_r == LAST_C) begin
              state_s = FIX;
            end else begin
              state_s = DIV;
            end
          end
        end
        FIX: begin
          if (special_r) begin
            result_s = INT_MIN;
            exc_s    = 1'b1;
          end else begin
            result_s = sign_r ? (~q_r + 32'd1) : q_r;
            exc_s    = 1'b0;
          end
          rdy_s   = 1'b1;
          busy_s  = 1'b0;
          state_s = DONE;
        end
        DONE: begin
          if (RDY_HOLD == 0) begin
            rdy_s   = 1'b0;
            state_s = IDLE;
          end else begin
            state_s = DONE;
          end
        end
        default: state_s = IDLE;
      endcase
    end
  end

  // State, datapath and output registers.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_r <= IDLE;  cnt_r <= '0;  mul_a_r <= '0;  mul_b_r <= '0;
      q_r <= '0;  divisor_r <= '0;  rem_r <= '0;  sign_r <= 1'b0;
      special_r <= 1'b0;  result_r <= '0;  exc_r <= 1'b0;
      rdy_r <= 1'b0;  busy_r <= 1'b0;
    end else begin
      state_r <= state_s;  cnt_r <= cnt_s;  mul_a_r <= mul_a_s;  mul_b_r <= mul_b_s;
      q_r <= q_s;  divisor_r <= divisor_s;  rem_r <= rem_s;  sign_r <= sign_s;
      special_r <= special_s;  result_r <= result_s;  exc_r <= exc_s;
      rdy_r <= rdy_s;  busy_r <= busy_s;
    end
  end

  assign data_result    = result_r;
  assign data_exception = exc_r;
  assign data_resultRDY = rdy_r;
  assign busy           = busy_r;
endmodule

// File: tb/tb_multdiv_controller.sv
// Randomized and directed bench for multdiv_controller against an arithmetic reference model.
module tb_multdiv_controller;
  localparam int LAT = 2;

  logic        clock = 1'b0;
  logic        resetn = 1'b0;
  logic        ctrl_MULT = 1'b0, ctrl_DIV = 1'b0;
  logic [31:0] data_operandA = 32'd0, data_operandB = 32'd0;
  logic [31:0] data_result;
  logic        data_exception, data_resultRDY, busy;
  int          n_pass = 0, n_total = 0;

  multdiv_controller #(.MULT_LAT(LAT), .RDY_HOLD(0)) dut (
    .clock (clock), .resetn (resetn), .ctrl_MULT (ctrl_MULT), .ctrl_DIV (ctrl_DIV),
    .data_operandA (data_operandA), .data_operandB (data_operandB),
    .data_result (data_result), .data_exception (data_exception),
    .data_resultRDY (data_resultRDY), .busy (busy)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Plain arithmetic: signed product / truncating quotient with the two exception cases.
  function automatic void ref_model(input logic is_mult, input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] r, output logic e, output int lat);
    longint p;
    int     q;
    if (is_mult) begin
      p   = longint'($signed(a)) * longint'($signed(b));
      r   = p[31:0];
      e   = (p != longint'($signed(r)));
      lat = LAT;
    end else if (b == 32'd0) begin
      r = 32'd0; e = 1'b1; lat = 1;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      r = 32'h8000_0000; e = 1'b1; lat = 33;
    end else begin
      q = $signed(a) / $signed(b);
      r = q; e = 1'b0; lat = 33;
    end
  endfunction

  task automatic run_op(input logic m, input logic d, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] er;
    logic        ee;
    int          el, got;
    ref_model(m, a, b, er, ee, el);
    ctrl_MULT = m; ctrl_DIV = d; data_operandA = a; data_operandB = b;
    @(posedge clock); #1;
    ctrl_MULT = 1'b0; ctrl_DIV = 1'b0;
    data_operandA = $urandom; data_operandB = $urandom;
    check("busy_e0", 64'(busy), 64'd1);
    check("rdy_low_e0", 64'(data_resultRDY), 64'd0);
    got = 999;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clock); #1;
      if (data_resultRDY) begin
        got = k;
        break;
      end
    end
    check($sformatf("lat %0h/%0h", a, b), 64'(got), 64'(el));
    check($sformatf("result %0h/%0h", a, b), 64'(data_result), 64'(er));
    check($sformatf("exc %0h/%0h", a, b), 64'(data_exception), 64'(ee));
    check("busy_at_rdy", 64'(busy), 64'd0);
    @(posedge clock); #1;
    check("rdy_pulse", 64'(data_resultRDY), 64'd0);
    check("hold_result", 64'(data_result), 64'(er));
  endtask

  initial begin
    int          first, pulses, sel;
    logic [31:0] ra, rb, first_res;
    // Reset held with ctrl noise.
    for (int k = 0; k < 6; k++) begin
      ctrl_MULT = 1'($urandom); ctrl_DIV = 1'($urandom);
      data_operandA = $urandom; data_operandB = $urandom;
      @(posedge clock); #1;
      check("rst_result", 64'(data_result), 64'd0);
      check("rst_exc", 64'(data_exception), 64'd0);
      check("rst_rdy", 64'(data_resultRDY), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
    end
    ctrl_MULT = 1'b0; ctrl_DIV = 1'b0;
    resetn = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clock); #1;
      check("idle_rdy", 64'(data_resultRDY), 64'd0);
      check("idle_busy", 64'(busy), 64'd0);
    end

    // Directed cases.
    run_op(1'b1, 1'b0, 32'd7, 32'hFFFF_FFFA);
    run_op(1'b1, 1'b0, 32'h0001_0000, 32'h0001_0000);
    run_op(1'b1, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op(1'b0, 1'b1, 32'hFFFF_FF9C, 32'd7);
    run_op(1'b0, 1'b1, 32'd100, 32'hFFFF_FFF9);
    run_op(1'b0, 1'b1, 32'd3, 32'd5);
    run_op(1'b0, 1'b1, 32'd5, 32'd0);
    run_op(1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op(1'b0, 1'b1, 32'h8000_0000, 32'd1);
    run_op(1'b1, 1'b1, 32'd6, 32'd3);

    // Abort: DIV 1000/3 replaced by MULT 3x4 at E10.
    ctrl_DIV = 1'b1; data_operandA = 32'd1000; data_operandB = 32'd3;
    @(posedge clock); #1;
    ctrl_DIV = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      @(posedge clock); #1;
      check("abort_no_rdy", 64'(data_resultRDY), 64'd0);
    end
    ctrl_MULT = 1'b1; data_operandA = 32'd3; data_operandB = 32'd4;
    @(posedge clock); #1;
    ctrl_MULT = 1'b0;
    first = 999; pulses = 0; first_res = 32'd0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clock); #1;
      if (data_resultRDY) begin
        pulses++;
        if (first == 999) begin
          first = k; first_res = data_result;
        end
      end
    end
    check("abort_lat", 64'(first), 64'(LAT));
    check("abort_result", 64'(first_res), 64'd12);
    check("abort_pulses", 64'(pulses), 64'd1);

    // Reset pulse mid-divide drops the op.
    ctrl_DIV = 1'b1; data_operandA = 32'd1000; data_operandB = 32'd3;
    @(posedge clock); #1;
    ctrl_DIV = 1'b0;
    for (int k = 1; k <= 4; k++) @(posedge clock);
    #1 resetn = 1'b0;
    #2 check("midrst_busy", 64'(busy), 64'd0);
    #2 resetn = 1'b1;
    pulses = 0;
    for (int k = 0; k < 45; k++) begin
      @(posedge clock); #1;
      if (data_resultRDY) pulses++;
    end
    check("midrst_no_rdy", 64'(pulses), 64'd0);

    // Randomized operations.
    for (int i = 0; i < 60; i++) begin
      sel = $urandom_range(0, 2);
      ra  = $urandom;
      case ($urandom_range(0, 5))
        0: rb = 32'd0;
        1: rb = 32'($urandom_range(1, 20));
        2: rb = 32'd0 - 32'($urandom_range(1, 20));
        3: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        4: begin ra = 32'($urandom_range(0, 70000)); rb = 32'($urandom_range(0, 70000)); end
        default: rb = $urandom;
      endcase
      run_op(sel != 1, sel != 0, ra, rb);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
